// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, fetch entry type and PC helper
// for the instruction fetch stage.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam int PC_WIDTH = XLEN;
  localparam int INSTR_WIDTH = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  // Clear the byte-offset bits of a fetch target.
  function automatic pc_t align_pc(pc_t pc);
    return pc & ~pc_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: DEPTH-entry in-order allocate/fill/pop fetch queue.
// Ports: alloc/alloc_pc (tail), fill/fill_data (fill pointer),
// pop (head), clear (flush), head_* (head entry), count
// (allocated entries), pending (allocated but unfilled).
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc,
  input  logic [PC_WIDTH-1:0]    alloc_pc,
  input  logic                   fill,
  input  logic [INSTR_WIDTH-1:0] fill_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic                   head_valid,
  output logic [PC_WIDTH-1:0]    head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr,
  output logic [CW-1:0]          count,
  output logic [CW-1:0]          pending
);

  fetch_entry_t     ent_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [PW-1:0]    fill_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
    end else if (clear) begin
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
    end else begin
      if (alloc) begin
        ent_q[tail_q].pc <= alloc_pc;
        filled_q[tail_q] <= 1'b0;
        tail_q <= tail_q + PW'(1);
      end
      if (fill) begin
        ent_q[fill_q].instr <= fill_data;
        filled_q[fill_q] <= 1'b1;
        fill_q <= fill_q + PW'(1);
      end
      // Drop the filled flag so an empty head never looks valid.
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q <= head_q + PW'(1);
      end
      cnt_q  <= cnt_q + CW'(alloc) - CW'(pop);
      pend_q <= pend_q + CW'(alloc) - CW'(fill);
    end
  end

  assign head_valid = filled_q[head_q];
  assign head_pc    = ent_q[head_q].pc;
  assign head_instr = ent_q[head_q].instr;
  assign count      = cnt_q;
  assign pending    = pend_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: fetch PC, imem request gating, redirect flush and
// discard of stale responses. Ports: redir_* from execute,
// imem_* to instruction memory, if_* valid/ready to IF/ID.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redir_valid_i,
  input  logic [PC_WIDTH-1:0]    redir_pc_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   if_valid_o,
  input  logic                   if_ready_i,
  output logic [PC_WIDTH-1:0]    if_pc_o,
  output logic [INSTR_WIDTH-1:0] if_instr_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q;
  logic [CW-1:0]       discard_q;
  logic [CW-1:0]       alloc_cnt;
  logic [CW-1:0]       pend_cnt;
  logic [CW:0]         used;
  logic                grant;
  logic                dropping;
  logic                fill;
  logic                pop;

  // Credits come from registered counts only, so every
  // outstanding request (live or discarded) has a slot.
  assign used = {1'b0, alloc_cnt} + {1'b0, discard_q};
  assign imem_req_o = !rst && !redir_valid_i
                   && (used < (CW + 1)'(DEPTH));
  assign imem_addr_o = pc_q;

  assign grant    = imem_req_o && imem_gnt_i;
  assign dropping = (discard_q != '0);
  assign fill     = imem_rvalid_i && !dropping
                 && !redir_valid_i;
  assign pop      = if_valid_o && if_ready_i
                 && !redir_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else if (redir_valid_i) begin
      pc_q      <= align_pc(redir_pc_i);
      // Every unfilled entry still owes a response; one
      // arriving right now is already accounted for.
      discard_q <= discard_q + pend_cnt
                 - CW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        pc_q <= pc_q + PC_WIDTH'(INSTR_BYTES);
      end
      if (imem_rvalid_i && dropping) begin
        discard_q <= discard_q - CW'(1);
      end
    end
  end

  ifetch_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .alloc     (grant),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_data (imem_rdata_i),
    .pop       (pop),
    .clear     (redir_valid_i),
    .head_valid(if_valid_o),
    .head_pc   (if_pc_o),
    .head_instr(if_instr_o),
    .count     (alloc_cnt),
    .pending   (pend_cnt)
  );

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed tests for ifetch against a small
// in-order instruction memory model with variable latency.
module tb_ifetch;

  localparam logic [31:0] K = 32'hDEAD_BEEF;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir_valid_i = 1'b0;
  logic [31:0] redir_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;

  int checks = 0;
  int passes = 0;

  int mem_lat = 1;
  bit lat_rand = 0;
  bit gnt_rand = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] a;
    int          due;
  } rq_t;
  rq_t q[$];

  ifetch dut (
    .clk          (clk),
    .rst          (rst),
    .redir_valid_i(redir_valid_i),
    .redir_pc_i   (redir_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_ready_i   (if_ready_i),
    .if_pc_o      (if_pc_o),
    .if_instr_o   (if_instr_o)
  );

  always #5 clk = ~clk;

  // Memory: records grants at the edge, answers in order
  // after lat cycles, drives gnt/rvalid 1 time unit later.
  always @(posedge clk) begin
    int lat;
    cyc = cyc + 1;
    lat = lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
    if (rst) begin
      q.delete();
    end else begin
      if (imem_rvalid_i) q.delete(0);
      if (imem_req_o && imem_gnt_i)
        q.push_back('{imem_addr_o, cyc + lat - 1});
    end
    #1;
    imem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = q[0].a ^ K;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_ready_i = 1'b0;
    redir_valid_i = 1'b0;
    repeat (3) step;
    #1;
    checks++;
    if (if_valid_o !== 1'b0)
      $display("FAIL rst_valid got %b want 0", if_valid_o);
    else passes++;
    checks++;
    if (imem_req_o !== 1'b0)
      $display("FAIL rst_req got %b want 0", imem_req_o);
    else passes++;
    checks++;
    if (if_pc_o !== 32'h0)
      $display("FAIL rst_pc got %h want 0", if_pc_o);
    else passes++;
    checks++;
    if (if_instr_o !== 32'h0)
      $display("FAIL rst_instr got %h want 0", if_instr_o);
    else passes++;
  endtask

  task automatic test_start;
    logic [31:0] p;
    rst = 1'b0;
    if_ready_i = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC)
      $display("FAIL start_req got %b/%h want 1/%h",
               imem_req_o, imem_addr_o, RST_PC);
    else passes++;
    step;
    checks++;
    if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h8000_0004)
      $display("FAIL start_lat got %b/%h want 0/80000004",
               if_valid_o, imem_addr_o);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      step;
      p = RST_PC + 32'(4 * i);
      checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== p
          || if_instr_o !== (p ^ K))
        $display("FAIL start_seq got %b/%h/%h want 1/%h/%h",
                 if_valid_o, if_pc_o, if_instr_o, p, p ^ K);
      else passes++;
    end
  endtask

  task automatic test_stall;
    logic exp_req;
    logic [31:0] p;
    if_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      exp_req = (i == 0);
      checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0004
          || if_instr_o !== (32'h8000_0004 ^ K))
        $display("FAIL stall_hold got %b/%h/%h want 1/80000004",
                 if_valid_o, if_pc_o, if_instr_o);
      else passes++;
      checks++;
      if (imem_req_o !== exp_req)
        $display("FAIL stall_req got %b want %b",
                 imem_req_o, exp_req);
      else passes++;
    end
    if_ready_i = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b0)
      $display("FAIL stall_credit got %b want 0", imem_req_o);
    else passes++;
    step;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0014
        || if_pc_o !== 32'h8000_0008)
      $display("FAIL stall_resume got %b/%h/%h want 1/80000014/80000008",
               imem_req_o, imem_addr_o, if_pc_o);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      step;
      p = 32'h8000_000C + 32'(4 * i);
      checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== p)
        $display("FAIL stall_drain got %b/%h want 1/%h",
                 if_valid_o, if_pc_o, p);
      else passes++;
    end
  endtask

  task automatic test_redirect_outstanding;
    rst = 1'b1;
    step;
    rst = 1'b0;
    if_ready_i = 1'b0;
    mem_lat = 3;
    step;
    step;
    redir_valid_i = 1'b1;
    redir_pc_i = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req_o !== 1'b0)
      $display("FAIL redir_noreq got %b want 0", imem_req_o);
    else passes++;
    step;
    redir_valid_i = 1'b0;
    mem_lat = 1;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0100
        || if_valid_o !== 1'b0)
      $display("FAIL redir_addr got %b/%h/%b want 1/00000100/0",
               imem_req_o, imem_addr_o, if_valid_o);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if (if_valid_o !== 1'b0)
        $display("FAIL redir_drop got %b/%h want 0",
                 if_valid_o, if_pc_o);
      else passes++;
    end
    step;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0000_0100
        || if_instr_o !== (32'h0000_0100 ^ K))
      $display("FAIL redir_first got %b/%h/%h want 1/00000100",
               if_valid_o, if_pc_o, if_instr_o);
    else passes++;
    if_ready_i = 1'b1;
    step;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0000_0104)
      $display("FAIL redir_second got %b/%h want 1/00000104",
               if_valid_o, if_pc_o);
    else passes++;
  endtask

  task automatic test_redirect_rvalid_pop;
    redir_valid_i = 1'b1;
    redir_pc_i = 32'h0000_2000;
    step;
    redir_valid_i = 1'b0;
    #1;
    checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1
        || imem_addr_o !== 32'h0000_2000)
      $display("FAIL rvpop_addr got %b/%b/%h want 0/1/00002000",
               if_valid_o, imem_req_o, imem_addr_o);
    else passes++;
    step;
    checks++;
    if (if_valid_o !== 1'b0)
      $display("FAIL rvpop_stale got %b/%h want 0",
               if_valid_o, if_pc_o);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      step;
      checks++;
      if (if_valid_o !== 1'b1
          || if_pc_o !== 32'h0000_2000 + 32'(4 * i)
          || if_instr_o !== ((32'h0000_2000 + 32'(4 * i)) ^ K))
        $display("FAIL rvpop_seq got %b/%h/%h want 1/%h",
                 if_valid_o, if_pc_o, if_instr_o,
                 32'h0000_2000 + 32'(4 * i));
      else passes++;
    end
  endtask

  task automatic test_wrap;
    redir_valid_i = 1'b1;
    redir_pc_i = 32'hFFFF_FFFD;
    step;
    redir_valid_i = 1'b0;
    #1;
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC)
      $display("FAIL wrap_addr0 got %h want fffffffc", imem_addr_o);
    else passes++;
    step;
    checks++;
    if (imem_addr_o !== 32'h0000_0000)
      $display("FAIL wrap_addr1 got %h want 00000000", imem_addr_o);
    else passes++;
    step;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC)
      $display("FAIL wrap_pc0 got %b/%h want 1/fffffffc",
               if_valid_o, if_pc_o);
    else passes++;
    step;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0000_0000)
      $display("FAIL wrap_pc1 got %b/%h want 1/00000000",
               if_valid_o, if_pc_o);
    else passes++;
  endtask

  task automatic test_random;
    logic [31:0] exp_pc = '0;
    int pops = 0;
    gnt_rand = 1;
    lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      step;
      if_ready_i = 1'($urandom_range(0, 1));
      if (i == 0 || i == 150) begin
        redir_valid_i = 1'b1;
        redir_pc_i = (i == 0) ? 32'h0000_4000 : 32'h0000_8000;
      end else if (i == 151) begin
        redir_valid_i = 1'b1;
        redir_pc_i = 32'h0000_9002;
      end else begin
        redir_valid_i = 1'b0;
      end
      #1;
      checks++;
      if (q.size() > 4)
        $display("FAIL rand_outstanding got %0d want <=4", q.size());
      else passes++;
      if (redir_valid_i) begin
        exp_pc = {redir_pc_i[31:2], 2'b00};
      end else if (if_valid_o && if_ready_i) begin
        checks++;
        if (if_pc_o !== exp_pc || if_instr_o !== (exp_pc ^ K))
          $display("FAIL rand_seq got %h/%h want %h/%h",
                   if_pc_o, if_instr_o, exp_pc, exp_pc ^ K);
        else passes++;
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    redir_valid_i = 1'b0;
    gnt_rand = 0;
    lat_rand = 0;
    checks++;
    if (pops < 50)
      $display("FAIL rand_progress got %0d pops want >=50", pops);
    else passes++;
  endtask

  task automatic test_mid_reset;
    if_ready_i = 1'b0;
    repeat (4) step;
    rst = 1'b1;
    step;
    #1;
    checks++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0
        || if_pc_o !== 32'h0 || if_instr_o !== 32'h0)
      $display("FAIL mrst_state got %b/%b/%h/%h want 0/0/0/0",
               if_valid_o, imem_req_o, if_pc_o, if_instr_o);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC)
      $display("FAIL mrst_addr got %b/%h want 1/%h",
               imem_req_o, imem_addr_o, RST_PC);
    else passes++;
    step;
    checks++;
    if (if_valid_o !== 1'b0)
      $display("FAIL mrst_lat got %b want 0", if_valid_o);
    else passes++;
    step;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== RST_PC
        || if_instr_o !== (RST_PC ^ K))
      $display("FAIL mrst_first got %b/%h/%h want 1/%h",
               if_valid_o, if_pc_o, if_instr_o, RST_PC);
    else passes++;
  endtask

  initial begin
    test_reset;
    test_start;
    test_stall;
    test_redirect_outstanding;
    test_redirect_rvalid_pop;
    test_wrap;
    test_random;
    test_mid_reset;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
